// File: rtl/dw_weight_loader.sv
// dw_weight_loader: streams depthwise kernels (KSIZE words each) from weight
// SRAM into a kernel FIFO. One kernel per consumer request, contiguous addresses
// across the whole layer.
// Optional feature macro: WLD_STALL_CNT_EN (enables the WAIT_REQ stall counter).
module dw_weight_loader #(
    parameter int DW    = 32,
    parameter int KSIZE = 9,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [15:0]   num_ch,
    input  logic          ker_req,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic          busy,
    output logic          done,
    output logic [31:0]   stall_cnt
);

    localparam int WCW = $clog2(KSIZE + 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(KSIZE - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        WAIT_REQ = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q;
    logic [15:0]    num_ch_q;
    logic [15:0]    ch_q;
    logic [WCW-1:0] word_q;
    logic           o_valid_q;
    logic           done_q;
    logic           last_word;
    logic           last_ch;

    assign last_word = (word_q == LAST_WORD);
    assign last_ch   = (ch_q == num_ch_q - 16'd1);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_ch != 16'd0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (last_word) begin
                    state_d = last_ch ? DONE : WAIT_REQ;
                end
            end
            WAIT_REQ: begin
                if (ker_req) begin
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, address/word/channel counters and output pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            num_ch_q  <= '0;
            ch_q      <= '0;
            word_q    <= '0;
            o_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_valid_q <= (state_q == FETCH);
            // done trails the DONE state by one cycle so it lands after the last o_valid
            done_q    <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start && num_ch != 16'd0) begin
                        addr_q   <= base_addr;
                        num_ch_q <= num_ch;
                        ch_q     <= '0;
                        word_q   <= '0;
                    end
                end
                FETCH: begin
                    // address keeps running across kernels: base + ch*KSIZE + word
                    addr_q <= addr_q + AW'(1);
                    if (last_word) begin
                        word_q <= '0;
                        if (!last_ch) begin
                            ch_q <= ch_q + 16'd1;
                        end
                    end else begin
                        word_q <= word_q + WCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WLD_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of WAIT_REQ cycles, cleared when a layer is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == IDLE && start) begin
            stall_q <= '0;
        end else if (state_q == WAIT_REQ && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign mem_rd_en = (state_q == FETCH);
    assign mem_addr  = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign o_valid   = o_valid_q;
    // SRAM data is already one cycle behind its read enable; qualifying it with the
    // delayed enable keeps o_data aligned with o_valid and zero otherwise.
    assign o_data    = o_valid_q ? mem_rd_data : '0;

endmodule

// File: tb/tb_dw_weight_loader.sv
// tb_dw_weight_loader: scoreboard bench for dw_weight_loader with a synchronous
// SRAM model. Honors WLD_STALL_CNT_EN for the stall counter expectation.
module tb_dw_weight_loader;

    localparam int DW    = 32;
    localparam int KSIZE = 9;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [15:0]   num_ch;
    logic          ker_req;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          busy;
    logic          done;
    logic [31:0]   stall_cnt;

    dw_weight_loader #(.DW(DW), .KSIZE(KSIZE), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_ch(num_ch), .ker_req(ker_req), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .o_data(o_data),
        .o_valid(o_valid), .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc, last_ov_cyc, words_exp;
    int rd_seen, ov_seen, done_seen;
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] data_q[$];

    function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous SRAM: data valid the cycle after the read enable, garbage otherwise
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= model(mem_addr);
        else           mem_rd_data <= 32'hDEADBEEF;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_seen++;
            if (addr_q.size() == 0) check("rd_unexpected", {16'h0, mem_addr}, 32'hFFFFFFFF);
            else begin
                logic [AW-1:0] ea;
                ea = addr_q.pop_front();
                check("rd_addr", {16'h0, mem_addr}, {16'h0, ea});
                data_q.push_back(model(ea));
            end
        end
        if (o_valid) begin
            ov_seen++;
            last_ov_cyc = cyc;
            if (data_q.size() == 0) check("ov_unexpected", o_data, 32'hFFFFFFFF);
            else check("o_data", o_data, data_q.pop_front());
        end
        if (done) begin
            done_seen++;
            if (words_exp > 0) check("done_lat", 32'(cyc - last_ov_cyc), 32'd1);
            else               check("done_lat0", 32'(cyc - start_cyc), 32'd2);
            check("done_busy", {31'h0, busy}, 32'd0);
        end
    end

    task automatic run_layer(input logic [AW-1:0] base, input int n, input int gap, input bit noise);
        int rdc, wcnt, exp_stall;
        for (int i = 0; i < n * KSIZE; i++) addr_q.push_back(base + AW'(i));
        words_exp = n * KSIZE;
        rd_seen = 0; ov_seen = 0; done_seen = 0;
        if (noise) begin
            @(negedge clk); ker_req = 1'b1;
            @(negedge clk); ker_req = 1'b0;
            check("idle_req_busy", {31'h0, busy}, 32'd0);
        end
        @(negedge clk);
        start = 1'b1; base_addr = base; num_ch = 16'(n); start_cyc = cyc;
        rdc = 0; wcnt = 0;
        for (int c = 0; c < n * (KSIZE + gap + 4) + 20 && done_seen == 0; c++) begin
            @(negedge clk);
            start = 1'b0; ker_req = 1'b0;
            base_addr = 16'h5555 ^ 16'(c); num_ch = 16'hFFFF;
            if (mem_rd_en) begin
                rdc++; wcnt = 0;
                if (noise && rdc % KSIZE == 4) begin
                    start = 1'b1; ker_req = 1'b1;
                end
            end else if (busy && rdc > 0 && rdc % KSIZE == 0 && rdc < n * KSIZE) begin
                wcnt++;
                if (wcnt == gap) ker_req = 1'b1;
            end
        end
        start = 1'b0; ker_req = 1'b0;
        if (done_seen == 0) check("done_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        check("rd_count", 32'(rd_seen), 32'(n * KSIZE));
        check("ov_count", 32'(ov_seen), 32'(n * KSIZE));
        check("done_count", 32'(done_seen), 32'd1);
        check("addr_q_left", 32'(addr_q.size()), 32'd0);
        check("data_q_left", 32'(data_q.size()), 32'd0);
        check("busy_end", {31'h0, busy}, 32'd0);
`ifdef WLD_STALL_CNT_EN
        exp_stall = (n > 1) ? (n - 1) * gap : 0;
`else
        exp_stall = 0;
`endif
        check("stall_cnt", stall_cnt, 32'(exp_stall));
        addr_q.delete(); data_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_ch = '0; ker_req = 1'b0;
        words_exp = 0; last_ov_cyc = 0; start_cyc = 0;
        repeat (3) @(negedge clk);
        check("rst_rd_en", {31'h0, mem_rd_en}, 32'd0);
        check("rst_o_valid", {31'h0, o_valid}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_addr", {16'h0, mem_addr}, 32'd0);
        check("rst_o_data", o_data, 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_layer(16'h0100, 1, 0, 1'b0);   // single kernel
        run_layer(16'h0200, 3, 5, 1'b0);   // three kernels, 5-cycle waits
        run_layer(16'h0000, 0, 0, 1'b0);   // empty layer, also clears stall count
        run_layer(16'hFFFC, 1, 0, 1'b0);   // address wrap
        run_layer(16'h0400, 2, 2, 1'b1);   // start/ker_req noise ignored

        // reset during the 4th FETCH cycle
        for (int i = 0; i < KSIZE; i++) addr_q.push_back(16'h0300 + AW'(i));
        words_exp = KSIZE;
        @(negedge clk); start = 1'b1; base_addr = 16'h0300; num_ch = 16'd1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rd_en", {31'h0, mem_rd_en}, 32'd0);
        check("abort_o_valid", {31'h0, o_valid}, 32'd0);
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_addr", {16'h0, mem_addr}, 32'd0);
        check("abort_addr_left", 32'(addr_q.size()), 32'(KSIZE - 4));
        check("abort_data_left", 32'(data_q.size()), 32'd1);
        rst_n = 1'b1;
        addr_q.delete(); data_q.delete();
        @(negedge clk);
        run_layer(16'h0800, 1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dw_weight_loader.md
DW_WEIGHT_LOADER -- requirements
Module: dw_weight_loader

Interface
REQ-001 SHALL have parameter DW, default 32, weight word width.
REQ-002 SHALL have parameter KSIZE, default 9, words per depthwise kernel (3x3).
REQ-003 SHALL have parameter AW, default 16, weight SRAM address width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse launching a layer load.
REQ-007 SHALL have port base_addr  input  AW  first kernel word address, sampled on accepted start.
REQ-008 SHALL have port num_ch  input  16  channel count, sampled on accepted start.
REQ-009 SHALL have port ker_req  input  1  consumer pulse requesting the next kernel.
REQ-010 SHALL have port mem_rd_en  output  1  SRAM read enable.
REQ-011 SHALL have port mem_addr  output  AW  SRAM read address.
REQ-012 SHALL have port mem_rd_data  input  DW  SRAM data, valid one cycle after mem_rd_en.
REQ-013 SHALL have port o_data  output  DW  weight word to the kernel FIFO.
REQ-014 SHALL have port o_valid  output  1  o_data is a valid write this cycle (drives FIFO i_valid).
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last word of the last channel.
REQ-017 SHALL have port stall_cnt  output  32  cycles spent in WAIT_REQ during the current layer.

Function
REQ-018 SHALL implement states IDLE, FETCH, WAIT_REQ, DONE.
REQ-019 IDLE: start with num_ch>0 SHALL latch base_addr/num_ch, clear channel and word counters, go to FETCH; start with num_ch==0 SHALL go to DONE directly.
REQ-020 FETCH: SHALL assert mem_rd_en for exactly KSIZE consecutive cycles, mem_addr incrementing by 1 from the running address, no gaps.
REQ-021 o_valid/o_data SHALL equal mem_rd_en/mem_rd_data delayed one cycle; first o_valid arrives 1 cycle after first mem_rd_en.
REQ-022 After the KSIZE-th read: if channels remain, SHALL go to WAIT_REQ; otherwise to DONE.
REQ-023 WAIT_REQ: ker_req SHALL move to FETCH next cycle with address continuing contiguously (base_addr + ch*KSIZE).
REQ-024 ker_req in IDLE, FETCH or DONE SHALL be ignored (not queued).
REQ-025 DONE: SHALL pulse done for one cycle, arriving the cycle after the last o_valid, then return to IDLE.
REQ-026 start while busy SHALL be ignored, with no change to latched values.
REQ-027 mem_addr SHALL wrap modulo 2^AW without error.
REQ-028 Channel counter SHALL be 16 bits; num_ch=65535 SHALL load all 65535 kernels.

Reset
REQ-029 On rst_n low at posedge: state IDLE; mem_rd_en, o_valid, done, busy = 0; mem_addr, o_data, counters, stall_cnt = 0.
REQ-030 Reset mid-FETCH SHALL abort immediately; an o_valid pending from the prior read SHALL be suppressed.

Configuration
REQ-031 Macro WLD_STALL_CNT_EN defined: stall_cnt SHALL increment each WAIT_REQ cycle, saturate at 2^32-1, and clear on accepted start.
REQ-032 WLD_STALL_CNT_EN undefined: stall_cnt SHALL be constant 0, with no counter register synthesized.

Verification
REQ-033 start, base_addr=0x0100, num_ch=1, KSIZE=9 -> addresses 0x0100..0x0108 on 9 cycles, 9 o_valid, done 1 cycle after last, busy then 0.
REQ-034 num_ch=3, ker_req pulsed 5 cycles after each WAIT_REQ entry -> 27 words from contiguous addresses; with macro defined, stall_cnt=10 (5 cycles in each of 2 waits).
REQ-035 start, num_ch=0 -> no mem_rd_en, done asserted 2 cycles after start, stall_cnt=0.
REQ-036 base_addr=0xFFFC, num_ch=1, AW=16 -> addresses 0xFFFC..0xFFFF, 0x0000..0x0004.
REQ-037 rst_n low during 4th FETCH cycle -> next cycle mem_rd_en=0, o_valid=0, busy=0; a later start restarts cleanly from the new base_addr.
REQ-038 start and ker_req pulsed during FETCH -> both ignored; word count and addresses unchanged.
